// File: rtl/inv_substitute_if.sv
// Stage-word handshake bundle for the inverse substitution stage.
// The master starts a block with load/data_in, the slave reports busy/done
// and presents the substituted word on data_out.
interface inv_substitute_if;
    logic         load;
    logic [131:0] data_in;
    logic [131:0] data_out;
    logic         busy;
    logic         done;

    modport master (
        output load,
        output data_in,
        input  data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  data_in,
        output data_out,
        output busy,
        output done
    );
endinterface

// File: rtl/inv_substitute.sv
// Inverse SubBytes stage: replaces each of the 16 state bytes with its
// FIPS-197 inverse S-box value, LANES bytes per clock, header passes through.
// Group 0 is substituted in the load cycle itself, so a block takes 16/LANES
// edges and a new load may be accepted in the done cycle.
module inv_substitute #(
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    inv_substitute_if.slave bus
);

    localparam int N  = 16 / LANES;
    localparam int GW = 8 * LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A load goes straight to DONE when the whole block fits in one group.
    localparam state_t LOAD_TARGET = (N > 1) ? RUN : DONE;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_t         state;
    state_t         next_state;
    logic [3:0]     header_q;
    logic [127:0]   result_q;
    logic [127:0]   shift_q;
    logic [127:0]   result_next;
    logic [CW-1:0]  count_q;
    logic [GW-1:0]  group_in;
    logic [GW-1:0]  group_out;
    logic           advance;

    // The load cycle consumes group 0 directly from the bus.
    assign group_in = bus.load ? bus.data_in[127 -: GW] : shift_q[127 -: GW];
    assign advance  = (state == RUN) && !bus.load;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign group_out[GW-1-8*i -: 8] = INV_SBOX[group_in[GW-1-8*i -: 8]];
    end

    // Results enter from the LSB side so byte order is intact after N shifts.
    if (GW == 128) begin : g_full_width
        assign result_next = group_out;
    end else begin : g_partial_width
        assign result_next = {result_q[127-GW:0], group_out};
    end

    // Datapath registers: load restarts the block, RUN advances one group.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            header_q <= 4'h0;
            result_q <= 128'h0;
            shift_q  <= 128'h0;
            count_q  <= '0;
        end else if (bus.load) begin
            header_q <= bus.data_in[131:128];
            result_q <= result_next;
            shift_q  <= bus.data_in[127:0] << GW;
            count_q  <= CW'(1);
        end else if (advance) begin
            result_q <= result_next;
            shift_q  <= shift_q << GW;
            count_q  <= count_q + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; load always wins and restarts the block.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.load) next_state = LOAD_TARGET;
            end
            RUN: begin
                if (bus.load)                     next_state = LOAD_TARGET;
                else if (count_q == CW'(N - 1))   next_state = DONE;
            end
            DONE: begin
                if (bus.load) next_state = LOAD_TARGET;
                else          next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    assign bus.data_out = {header_q, result_q};

endmodule

// File: tb/tb_inv_substitute.sv
// Bench for inv_substitute: five instances (LANES = 1,2,4,8,16) share one
// stimulus stream. A block-level model (done N cycles after the last load,
// result = inverse S-box derived from GF(2^8) arithmetic) is checked every cycle.
module tb_inv_substitute;

    localparam int NINST = 5;

    typedef struct {
        logic [131:0] din;
        logic [131:0] dout;
    } vec_t;

    logic         clk;
    logic         n_rst;
    logic         load;
    logic [131:0] data_in;

    logic [131:0] out_w  [NINST];
    logic         busy_w [NINST];
    logic         done_w [NINST];

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];

    int           cnt      [NINST];
    logic [131:0] pend     [NINST];
    logic [131:0] last_out [NINST];
    int           done_seen [NINST];

    int           checks;
    int           errors;

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        inv_substitute_if bus_if ();
        assign bus_if.load    = load;
        assign bus_if.data_in = data_in;
        assign out_w[g]       = bus_if.data_out;
        assign busy_w[g]      = bus_if.busy;
        assign done_w[g]      = bus_if.done;

        inv_substitute #(.LANES(1 << g)) dut (
            .clk   (clk),
            .n_rst (n_rst),
            .bus   (bus_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Forward S-box from first principles, inverse table by inverting it.
    task automatic buildTables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            fwd_t[x] = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
    endtask

    function automatic logic [131:0] subWord(input logic [131:0] w, input bit inverse);
        logic [131:0] r = w;
        for (int b = 0; b < 16; b++)
            r[127-8*b -: 8] = inverse ? inv_t[w[127-8*b -: 8]] : fwd_t[w[127-8*b -: 8]];
        return r;
    endfunction

    // Block-level model: a load arms an N-cycle countdown, done at count 1.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int g = 0; g < NINST; g++) begin
                cnt[g]      <= 0;
                pend[g]     <= '0;
                last_out[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NINST; g++) begin
                if (load) begin
                    cnt[g]  <= 16 >> g;
                    pend[g] <= subWord(data_in, 1'b1);
                    if ((16 >> g) == 1) last_out[g] <= subWord(data_in, 1'b1);
                end else if (cnt[g] > 0) begin
                    cnt[g] <= cnt[g] - 1;
                    if (cnt[g] == 2) last_out[g] <= pend[g];
                end
            end
        end
    end

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every instance with the model; called once per cycle at negedge.
    task automatic checkOutput();
        for (int g = 0; g < NINST; g++) begin
            check($sformatf("done[L%0d]", 1 << g), 132'(done_w[g]), 132'(cnt[g] == 1));
            check($sformatf("busy[L%0d]", 1 << g), 132'(busy_w[g]), 132'(cnt[g] > 1));
            if (cnt[g] <= 1)
                check($sformatf("data_out[L%0d]", 1 << g), out_w[g], last_out[g]);
            if (done_w[g] === 1'b1) done_seen[g]++;
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [131:0] din);
        @(negedge clk);
        checkOutput();
        load    = ld;
        data_in = din;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 132'h0);
    endtask

    task automatic clearDoneSeen();
        for (int g = 0; g < NINST; g++) done_seen[g] = 0;
    endtask

    vec_t vecs [4];

    initial begin
        logic [131:0] w;
        logic [131:0] fw;
        checks  = 0;
        errors  = 0;
        load    = 1'b0;
        data_in = '0;
        n_rst   = 1'b0;
        clearDoneSeen();
        buildTables();

        vecs[0] = '{din: {4'hA, 128'h637C777BF26B6FC53001672BFED7AB76},
                    dout: {4'hA, 128'h000102030405060708090A0B0C0D0E0F}};
        vecs[1] = '{din: {4'h3, 128'h0}, dout: {4'h3, {16{8'h52}}}};
        vecs[2] = '{din: {4'h5, {16{8'h16}}}, dout: {4'h5, {16{8'hFF}}}};
        vecs[3] = '{din: {4'hF, {16{8'h63}}}, dout: {4'hF, 128'h0}};

        // Reset and idle, including an asynchronous reset between edges.
        idle(3);
        n_rst = 1'b1;
        idle(4);
        #2 n_rst = 1'b0;
        #1;
        for (int g = 0; g < NINST; g++)
            check($sformatf("async_reset_out[L%0d]", 1 << g),
                  {out_w[g], busy_w[g], done_w[g]}, 134'h0);
        idle(2);
        n_rst = 1'b1;
        idle(2);

        // Known-answer table on all lane widths.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b1, vecs[v].din);
            idle(18);
            for (int g = 0; g < NINST; g++)
                check($sformatf("kat%0d[L%0d]", v, 1 << g), out_w[g], vecs[v].dout);
        end

        // Back-to-back: second load lands in the LANES=4 done cycle.
        applyStimulus(1'b1, {4'h3, 128'h0});
        idle(3);
        applyStimulus(1'b1, {4'h5, {16{8'h16}}});
        idle(4);
        check("b2b_done[L4]", 132'(done_w[2]), 132'h1);
        check("b2b_data[L4]", out_w[2], {4'h5, {16{8'hFF}}});
        idle(18);

        // Restart mid-RUN: only the second block completes.
        clearDoneSeen();
        applyStimulus(1'b1, vecs[0].din);
        applyStimulus(1'b0, 132'h0);
        applyStimulus(1'b1, vecs[1].din);
        idle(18);
        check("restart_done_count[L4]", 132'(done_seen[2]), 132'd1);
        check("restart_done_count[L16]", 132'(done_seen[4]), 132'd2);
        check("restart_data[L4]", out_w[2], vecs[1].dout);

        // Reset pulse mid-RUN: no done, outputs back to zero.
        clearDoneSeen();
        applyStimulus(1'b1, vecs[2].din);
        applyStimulus(1'b0, 132'h0);
        #2 n_rst = 1'b0;
        #3 n_rst = 1'b1;
        idle(18);
        check("reset_mid_done_count[L4]", 132'(done_seen[2]), 132'd0);
        check("reset_mid_data[L4]", out_w[2], 132'h0);

        // Round trip through the forward S-box, each lane width.
        for (int r = 0; r < 20; r++) begin
            w  = {4'($urandom), $urandom, $urandom, $urandom, $urandom};
            fw = subWord(w, 1'b0);
            applyStimulus(1'b1, fw);
            idle(17);
            for (int g = 0; g < NINST; g++)
                check($sformatf("roundtrip%0d[L%0d]", r, 1 << g), out_w[g], w);
        end

        // Random load pattern, including held and back-to-back loads.
        for (int c = 0; c < 300; c++)
            applyStimulus(($urandom_range(0, 3) == 0),
                          {4'($urandom), $urandom, $urandom, $urandom, $urandom});
        idle(18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
